sound_frame_seq: RTL and testbench
==================================

# sound_frame_seq

APU frame sequencer: maintains the 16-bit system divider (DIV), detects the falling edge of the selected divider bit, and steps an 8-phase sequencer at 512 Hz. It emits single-cycle length, sweep and envelope strobes that clock the channel length counters, the channel-1 frequency sweep and the volume envelope units of channels 1, 2 and 4. It sits between the CPU-side timer/IO registers and the per-channel sound generators.

## Interface
- `CNT_W`, 16, divider width; DIV = `cnt[15:8]`.
- `SEQ_BIT_N`, 12, divider bit clocking the sequencer in normal speed (DIV bit 4).
- `SEQ_BIT_D`, 13, divider bit clocking the sequencer in double speed (DIV bit 5).
- `clk` in 1 system clock.
- `rst_n` in 1 asynchronous, active-low reset.
- `ce` in 1 4.194304 MHz tick qualifier; the divider advances only when high.
- `div_reset` in 1 CPU write to FF04; clears the divider.
- `double_speed` in 1 CGB double-speed flag; selects `SEQ_BIT_D`.
- `apu_enable` in 1 NR52 bit 7.
- `div` out 8 current DIV register value.
- `step` out 3 current sequencer step, i.e. the step the next event executes.
- `len_tick` out 1 one-cycle strobe to the length counters.
- `sweep_tick` out 1 one-cycle strobe to the ch1 sweep unit.
- `env_tick` out 1 one-cycle strobe to the envelope units.
- `len_next` out 1 high when the next event will not clock length (`step[0]==1`). Consumed by the length-enable write quirk.

## Operation
- **Divider.**
  - `cnt` increments by 1 (wrapping) on each `clk` with `ce=1`.
  - `div_reset=1` forces `cnt=0` and takes priority over `ce` in the same cycle.
- **Selected bit.** `sel = double_speed ? cnt[SEQ_BIT_D] : cnt[SEQ_BIT_N]`.
  - `sel_q` registers `sel` every cycle.
- **Frame event.** A frame event occurs when `sel_q=1` and `sel=0`, evaluated every `clk` regardless of `ce`.
  - Any 1→0 transition of `sel` counts, including one caused by `div_reset` or by toggling `double_speed`. This is a deliberate hardware-accurate quirk.
- **Step actions.** On a frame event with `apu_enable=1`:
  - Step 0: length.
  - Step 1: none.
  - Step 2: length + sweep.
  - Step 3: none.
  - Step 4: length.
  - Step 5: none.
  - Step 6: length + sweep.
  - Step 7: envelope.
  - After the actions, `step <= step+1`, wrapping 7→0.
- **APU disabled.** While `apu_enable=0`:
  - `step` is held at 0 and no strobes are issued.
  - The divider and `div` keep running.
  - When `apu_enable` rises, the first subsequent event executes step 0.
- **Strobe width.** Strobes are exactly one `clk` wide. Back-to-back events on consecutive cycles (spurious edges) each produce their own strobes.

## Timing
- **Reset values.** All outputs are 0 under reset: `cnt=0`, `sel_q=0`, `step=0`, `div=0`, all strobes 0, `len_next=0`.
- **`div`.** Registered; reflects `cnt[15:8]` in the same cycle `cnt` updates. There is no extra latency.
- **Strobe latency.** Strobes are registered and asserted in the cycle after the event edge is visible on `sel`. `step` updates in that same cycle.
- **Nominal rate.** In normal speed, events occur every 8192 `ce` ticks (512 Hz):
  - length: 256 Hz
  - sweep: 128 Hz
  - envelope: 64 Hz
- **Double speed.** Events occur every 16384 `ce` ticks. Because `ce` runs at twice the rate in double speed, the audio rates are unchanged.
- **Reset mid-operation.** Asserting `rst_n` low mid-count clears everything immediately (asynchronous assertion). Deassertion is synchronous to `clk`.
- **Enable edge cases.**
  - If `apu_enable` falls in the same cycle as an event, the event is dropped and `step` becomes 0.
  - If `apu_enable` rises in the same cycle as an event, the event executes step 0.

## Structure
- Shared `sound_pkg` holds:
  - `SEQ_LEN_MASK=8'b0101_0101`
  - `SEQ_SWEEP_MASK=8'b0100_0100`
  - `SEQ_ENV_MASK=8'b1000_0000`
  - the step type `logic [2:0]`
  - the 4.194304 MHz constant
- Strobes are decoded as `MASK[step]`.
- One natural sub-module is `sound_div_counter`: the divider, the `div_reset` priority and the selected-bit mux with its falling-edge detector. It outputs `div` and `frame_evt`.
- The top level holds the step counter, the enable gating and the strobe registers.

## Test plan
- **Reset.** Hold `ce=1` and `apu_enable=1`, then release reset → the first event occurs after `cnt` passes 0x1FFF→0x2000. That event emits `len_tick` only, and `step` becomes 1.
- **Full cycle.** Run 8 events → observe the strobe sequence L, –, L+S, –, L, –, L+S, E and `step` back at 0. This gives `len_tick`×4, `sweep_tick`×2, `env_tick`×1, each exactly 1 cycle wide.
- **DIV-reset quirk.** With `cnt=0x1000` (bit 12=1), pulse `div_reset` → one extra event occurs and `div` reads 0x00. With `cnt=0x0800`, pulse `div_reset` → no event.
- **APU gating.**
  - Disable at step 5 → `step` becomes 0 and no strobes appear while disabled.
  - Re-enable → the next event emits `len_tick` (step 0).
- **Double speed.** Set `double_speed=1` → events are 16384 `ce` apart. Toggling `double_speed` while `cnt[12]=1` and `cnt[13]=0` → one spurious event.
- **Priority and `len_next`.**
  - `div_reset` and `ce` in the same cycle → `cnt=0`.
  - `len_next` reads 1 exactly when `step` is odd.

Source files
------------

// File: rtl/sound_pkg.sv
// sound_pkg: shared APU constants, step type and frame-sequencer action masks.
package sound_pkg;
    localparam int unsigned CE_HZ = 4194304;
    localparam int CNT_W = 16;
    localparam int SEQ_BIT_N = 12;
    localparam int SEQ_BIT_D = 13;
    typedef logic [2:0] step_t;
    // Bit n of each mask is set when sequencer step n performs that action.
    localparam logic [7:0] SEQ_LEN_MASK = 8'b0101_0101;
    localparam logic [7:0] SEQ_SWEEP_MASK = 8'b0100_0100;
    localparam logic [7:0] SEQ_ENV_MASK = 8'b1000_0000;
endpackage

// File: rtl/sound_div_counter.sv
// sound_div_counter: system divider with FF04 reset and falling-edge detect of the sequencer bit.
// Ports: clk, rst_n (async active-low), ce (divider tick), div_reset (FF04 write, wins over ce),
//        double_speed (select SEQ_BIT_D), div (DIV register), frame_evt (combinational frame event).
module sound_div_counter
    import sound_pkg::*;
#(
    parameter int CNT_W = sound_pkg::CNT_W,
    parameter int SEQ_BIT_N = sound_pkg::SEQ_BIT_N,
    parameter int SEQ_BIT_D = sound_pkg::SEQ_BIT_D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       div_reset,
    input  logic       double_speed,
    output logic [7:0] div,
    output logic       frame_evt
);
    logic [CNT_W-1:0] cnt;
    logic sel, sel_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sel_q <= 1'b0;
        end else begin
            cnt <= div_reset ? '0 : ce ? cnt + 1'b1 : cnt;
            sel_q <= sel;
        end
    end
    assign sel = double_speed ? cnt[SEQ_BIT_D] : cnt[SEQ_BIT_N];
    // Any falling edge counts, including ones caused by div_reset or a speed switch.
    assign frame_evt = sel_q & ~sel;
    assign div = cnt[CNT_W-1 -: 8];
endmodule

// File: rtl/sound_frame_seq.sv
// sound_frame_seq: 512 Hz APU frame sequencer issuing length, sweep and envelope strobes.
// Ports: clk, rst_n (async active-low), ce, div_reset, double_speed, apu_enable (NR52.7),
//        div (DIV register), step (step the next event executes), len_tick/sweep_tick/env_tick
//        (one-cycle strobes), len_next (next event will not clock length).
module sound_frame_seq
    import sound_pkg::*;
#(
    parameter int CNT_W = sound_pkg::CNT_W,
    parameter int SEQ_BIT_N = sound_pkg::SEQ_BIT_N,
    parameter int SEQ_BIT_D = sound_pkg::SEQ_BIT_D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       div_reset,
    input  logic       double_speed,
    input  logic       apu_enable,
    output logic [7:0] div,
    output logic [2:0] step,
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       len_next
);
    logic frame_evt, fire;
    sound_div_counter #(
        .CNT_W(CNT_W),
        .SEQ_BIT_N(SEQ_BIT_N),
        .SEQ_BIT_D(SEQ_BIT_D)
    ) u_div (
        .clk(clk),
        .rst_n(rst_n),
        .ce(ce),
        .div_reset(div_reset),
        .double_speed(double_speed),
        .div(div),
        .frame_evt(frame_evt)
    );
    assign fire = frame_evt & apu_enable;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            len_tick <= 1'b0;
            sweep_tick <= 1'b0;
            env_tick <= 1'b0;
        end else begin
            len_tick <= fire & SEQ_LEN_MASK[step];
            sweep_tick <= fire & SEQ_SWEEP_MASK[step];
            env_tick <= fire & SEQ_ENV_MASK[step];
            // A disabled APU pins the sequencer to step 0, even on an event cycle.
            step <= !apu_enable ? '0 : frame_evt ? step + 1'b1 : step;
        end
    end
    assign len_next = step[0];
endmodule

// File: tb/tb_sound_frame_seq.sv
// tb_sound_frame_seq: directed self-checking bench for sound_frame_seq.
module tb_sound_frame_seq;
    logic clk, rst_n, ce, div_reset, double_speed, apu_enable;
    logic [7:0] div;
    logic [2:0] step;
    logic len_tick, sweep_tick, env_tick, len_next;
    logic [2:0] stb;
    int tests = 0, fails = 0;
    int n_len, n_sweep, n_env, n;
    logic [2:0] m_step;
    // {len, sweep, env} expected for each step
    logic [2:0] act_tbl [8] = '{3'b100, 3'b000, 3'b110, 3'b000, 3'b100, 3'b000, 3'b110, 3'b001};

    sound_frame_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .ce(ce),
        .div_reset(div_reset),
        .double_speed(double_speed),
        .apu_enable(apu_enable),
        .div(div),
        .step(step),
        .len_tick(len_tick),
        .sweep_tick(sweep_tick),
        .env_tick(env_tick),
        .len_next(len_next)
    );

    assign stb = {len_tick, sweep_tick, env_tick};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance cnt by exactly n, then freeze it and let sel_q settle.
    task automatic run(input int cycles);
        ce = 1;
        repeat (cycles) tick();
        ce = 0;
        tick();
    endtask

    // Spurious event from a speed toggle while cnt[12]=1, cnt[13]=0 and cnt frozen.
    task automatic pulse(input string tag);
        logic [2:0] e;
        e = apu_enable ? act_tbl[m_step] : 3'b000;
        double_speed = 1;
        tick();
        chk({tag, "_stb"}, stb, e);
        n_len += len_tick;
        n_sweep += sweep_tick;
        n_env += env_tick;
        m_step = apu_enable ? m_step + 3'd1 : 3'd0;
        chk({tag, "_step"}, step, m_step);
        chk({tag, "_len_next"}, len_next, m_step[0]);
        double_speed = 0;
        tick();
        chk({tag, "_width"}, stb, 3'b000);
    endtask

    task automatic wait_step(input int budget, output int got);
        logic [2:0] p;
        p = step;
        got = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (step !== p) begin
                got = i;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 0; ce = 1; apu_enable = 1; div_reset = 0; double_speed = 0;
        m_step = 0; n_len = 0; n_sweep = 0; n_env = 0;
        repeat (3) tick();
        chk("rst_div", div, 8'h00);
        chk("rst_step", step, 3'd0);
        chk("rst_stb", stb, 3'b000);
        chk("rst_len_next", len_next, 1'b0);
        rst_n = 1;
        wait_step(9000, n);
        chk("first_evt_delay", n, 8193);
        chk("first_evt_stb", stb, 3'b100);
        chk("first_evt_step", step, 3'd1);
        chk("first_evt_div", div, 8'h20);
        wait_step(9000, n);
        chk("period_normal", n, 8192);
        chk("step1_stb", stb, 3'b000);
        chk("step1_step", step, 3'd2);
        chk("step2_len_next", len_next, 1'b0);
        m_step = 2;
        div_reset = 1; ce = 0;
        tick();
        div_reset = 0;
        tick();
        chk("divrst_div", div, 8'h00);
        chk("divrst_low_no_evt", step, 3'd2);
        run(12'h800);
        chk("div_0800", div, 8'h08);
        div_reset = 1;
        tick();
        div_reset = 0;
        tick();
        tick();
        chk("quirk_0800_step", step, 3'd2);
        chk("quirk_0800_stb", stb, 3'b000);
        run(16'h1000);
        chk("div_1000", div, 8'h10);
        div_reset = 1; ce = 1;
        tick();
        chk("prio_div", div, 8'h00);
        div_reset = 0; ce = 0;
        tick();
        chk("quirk_1000_stb", stb, 3'b110);
        chk("quirk_1000_step", step, 3'd3);
        m_step = 3;
        tick();
        chk("quirk_1000_width", stb, 3'b000);
        run(16'h1000);
        n_len = 0; n_sweep = 0; n_env = 0;
        for (int i = 0; i < 8; i++) pulse("cycle");
        chk("cycle_len_cnt", n_len, 4);
        chk("cycle_sweep_cnt", n_sweep, 2);
        chk("cycle_env_cnt", n_env, 1);
        chk("cycle_step_back", step, 3'd3);
        pulse("to_step4");
        pulse("to_step5");
        apu_enable = 0;
        tick();
        m_step = 0;
        chk("dis_step", step, 3'd0);
        chk("dis_stb", stb, 3'b000);
        pulse("dis_evt_a");
        pulse("dis_evt_b");
        apu_enable = 1;
        tick();
        pulse("reen");
        apu_enable = 0;
        pulse("fall_with_evt");
        apu_enable = 1;
        pulse("rise_with_evt");
        double_speed = 1;
        tick();
        chk("ds_toggle_stb", stb, 3'b000);
        chk("ds_toggle_step", step, 3'd2);
        div_reset = 1;
        tick();
        div_reset = 0;
        chk("ds_divrst_div", div, 8'h00);
        chk("ds_divrst_step", step, 3'd2);
        ce = 1;
        wait_step(17000, n);
        ce = 0;
        chk("period_double", n, 16385);
        chk("ds_evt_stb", stb, 3'b110);
        chk("ds_evt_step", step, 3'd3);
        chk("ds_len_next", len_next, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
